// File: rtl/encipher.sv
// rtl/encipher.sv - RC5 block encryption engine with external synchronous subkey table; option macro ENCIPHER_MERGE_XOR_EN
module barrel_rotator #(
  parameter int W     = 32,
  parameter int ROT_W = $clog2(W)
) (
  input  logic [W-1:0]     i_data,
  input  logic [ROT_W-1:0] i_amt,
  input  logic             i_left,
  output logic [W-1:0]     o_data
);

  logic [ROT_W-1:0] w_amt;
  logic [W-1:0]     w_tmp;

  // A right rotation by n is a left rotation by W-n, so only left stages exist
  always_comb begin
    w_amt = i_left ? i_amt : (ROT_W'(0) - i_amt);
    w_tmp = i_data;
    for (int s = 0; s < ROT_W; s++) begin
      if (w_amt[s]) begin
        w_tmp = (w_tmp << (1 << s)) | (w_tmp >> (W - (1 << s)));
      end
    end
    o_data = w_tmp;
  end

endmodule

module encipher #(
  parameter int  W         = 32,
  parameter int  R         = 12,
  localparam int T         = 2 * (R + 1),
  localparam int T_LENGTH  = $clog2(T),
  localparam int ROT_VALUE = $clog2(W),
  localparam int CNT_W     = $clog2(R + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [W-1:0]        iA,
  input  logic [W-1:0]        iB,
  output logic [T_LENGTH-1:0] oS_address1,
  output logic [T_LENGTH-1:0] oS_address2,
  input  logic [W-1:0]        iS_sub_i1,
  input  logic [W-1:0]        iS_sub_i2,
  output logic [W-1:0]        oA_cipher,
  output logic [W-1:0]        oB_cipher,
  output logic                oDone
);

  typedef enum logic [3:0] {
    IDLE, INIT, WAIT_ADDR, READ_DATA, ADD_S01, CHANGE_ADDR,
    XOR_A, ROT_A, ADD_A, XOR_B, ROT_B, ADD_B, HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [T_LENGTH-1:0] r_addr1;
  logic [T_LENGTH-1:0] r_addr2;
  logic [CNT_W-1:0]    r_count;
  logic                r_done;
  logic                w_last_round;
  logic                w_first_pass;
  logic [W-1:0]        w_rot_in;
  logic [ROT_VALUE-1:0] w_rot_amt;
  logic [W-1:0]        w_rot_out;

  assign w_last_round = (r_count == CNT_W'(R));
  // Address 0 is only ever presented before the initial S[0]/S[1] add
  assign w_first_pass = (r_addr1 == '0);

`ifdef ENCIPHER_MERGE_XOR_EN
  // The rotator sees the XOR directly so XOR and rotate share one state
  always_comb begin
    w_rot_in  = r_a ^ r_b;
    w_rot_amt = r_b[ROT_VALUE-1:0];
    if (r_state == ROT_B) begin
      w_rot_amt = r_a[ROT_VALUE-1:0];
    end
  end
`else
  logic [W-1:0]         r_rot_data;
  logic [ROT_VALUE-1:0] r_rot_amt;

  assign w_rot_in  = r_rot_data;
  assign w_rot_amt = r_rot_amt;
`endif

  barrel_rotator #(.W(W), .ROT_W(ROT_VALUE)) u_rot (
    .i_data (w_rot_in),
    .i_amt  (w_rot_amt),
    .i_left (1'b1),
    .o_data (w_rot_out)
  );

  // State register; reset or a dropped iStart returns to IDLE
  always_ff @(posedge clk) begin
    if (rst || !iStart) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state sequencing through the round
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:        w_next = iStart ? INIT : IDLE;
      INIT:        w_next = WAIT_ADDR;
      WAIT_ADDR:   w_next = READ_DATA;
`ifdef ENCIPHER_MERGE_XOR_EN
      READ_DATA:   w_next = w_first_pass ? ADD_S01 : ROT_A;
      ADD_A:       w_next = ROT_B;
`else
      READ_DATA:   w_next = w_first_pass ? ADD_S01 : XOR_A;
      XOR_A:       w_next = ROT_A;
      ADD_A:       w_next = XOR_B;
      XOR_B:       w_next = ROT_B;
`endif
      ADD_S01:     w_next = CHANGE_ADDR;
      CHANGE_ADDR: w_next = WAIT_ADDR;
      ROT_A:       w_next = ADD_A;
      ROT_B:       w_next = ADD_B;
      ADD_B:       w_next = w_last_round ? HOLD : CHANGE_ADDR;
      HOLD:        w_next = HOLD;
      default:     w_next = IDLE;
    endcase
  end

  // Datapath: working words, subkey addresses, round counter and done flag
  always_ff @(posedge clk) begin
    if (rst || !iStart) begin
      r_a     <= '0;
      r_b     <= '0;
      r_addr1 <= '0;
      r_addr2 <= T_LENGTH'(1);
      r_count <= CNT_W'(1);
      r_done  <= 1'b0;
`ifndef ENCIPHER_MERGE_XOR_EN
      r_rot_data <= '0;
      r_rot_amt  <= '0;
`endif
    end else begin
      case (r_state)
        INIT: begin
          r_a <= iA;
          r_b <= iB;
        end
        ADD_S01: begin
          r_a <= r_a + iS_sub_i1;
          r_b <= r_b + iS_sub_i2;
        end
        CHANGE_ADDR: begin
          r_addr1 <= {r_count, 1'b0};
          r_addr2 <= {r_count, 1'b1};
        end
`ifndef ENCIPHER_MERGE_XOR_EN
        XOR_A: begin
          r_rot_data <= r_a ^ r_b;
          r_rot_amt  <= r_b[ROT_VALUE-1:0];
        end
        XOR_B: begin
          r_rot_data <= r_b ^ r_a;
          r_rot_amt  <= r_a[ROT_VALUE-1:0];
        end
`endif
        ROT_A: r_a <= w_rot_out;
        ADD_A: r_a <= r_a + iS_sub_i1;
        ROT_B: r_b <= w_rot_out;
        ADD_B: begin
          r_b <= r_b + iS_sub_i2;
          if (w_last_round) begin
            r_done <= 1'b1;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign oS_address1 = r_addr1;
  assign oS_address2 = r_addr2;
  assign oA_cipher   = r_a;
  assign oB_cipher   = r_b;
  assign oDone       = r_done;

endmodule

// File: tb/tb_encipher.sv
// tb/tb_encipher.sv - directed self-checking bench for encipher (RC5-32/12, zero key)
module tb_encipher;

  localparam int W  = 32;
  localparam int R  = 12;
  localparam int T  = 2 * (R + 1);
  localparam int TL = $clog2(T);
`ifdef ENCIPHER_MERGE_XOR_EN
  localparam int LAT = 5 + 7 * R;
`else
  localparam int LAT = 5 + 9 * R;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          istart = 1'b0;
  logic [W-1:0]  ia = '0;
  logic [W-1:0]  ib = '0;
  logic [TL-1:0] addr1;
  logic [TL-1:0] addr2;
  logic [W-1:0]  s1 = '0;
  logic [W-1:0]  s2 = '0;
  logic [W-1:0]  oa;
  logic [W-1:0]  ob;
  logic          odone;

  logic [W-1:0] s_tab [0:T-1];

  int n_checks = 0;
  int n_errors = 0;
  int addr_bad = 0;
  bit trace_en = 1'b0;
  logic [TL-1:0] trace_q [$];

  always #5 clk = ~clk;

  encipher #(.W(W), .R(R)) dut (
    .clk         (clk),
    .rst         (rst),
    .iStart      (istart),
    .iA          (ia),
    .iB          (ib),
    .oS_address1 (addr1),
    .oS_address2 (addr2),
    .iS_sub_i1   (s1),
    .iS_sub_i2   (s2),
    .oA_cipher   (oa),
    .oB_cipher   (ob),
    .oDone       (odone)
  );

  // Synchronous-read subkey table
  always @(posedge clk) begin
    s1 <= s_tab[addr1];
    s2 <= s_tab[addr2];
  end

  // Address legality and trace capture
  always @(negedge clk) begin
    if (int'(addr1) >= T || int'(addr2) >= T || addr1[0] || addr2 != addr1 + TL'(1)) addr_bad++;
    if (trace_en && (trace_q.size() == 0 || trace_q[$] != addr1)) trace_q.push_back(addr1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] enc(input logic [31:0] a0, input logic [31:0] b0);
    logic [31:0] a, b;
    a = a0 + s_tab[0];
    b = b0 + s_tab[1];
    for (int i = 1; i <= R; i++) begin
      a = rotl(a ^ b, int'(b[4:0])) + s_tab[2*i];
      b = rotl(b ^ a, int'(a[4:0])) + s_tab[2*i+1];
    end
    return {a, b};
  endfunction

  function automatic logic [63:0] dec(input logic [31:0] a0, input logic [31:0] b0);
    logic [31:0] a, b;
    a = a0;
    b = b0;
    for (int i = R; i >= 1; i--) begin
      b = rotr(b - s_tab[2*i+1], int'(a[4:0])) ^ a;
      a = rotr(a - s_tab[2*i], int'(b[4:0])) ^ b;
    end
    return {a - s_tab[0], b - s_tab[1]};
  endfunction

  task automatic wait_done(output int lat);
    lat = -1;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (odone) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    istart = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int lat;
    exp = enc(a, b);
    go_idle();
    ia = a;
    ib = b;
    istart = 1'b1;
    wait_done(lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'(LAT));
    check_eq({tag, "_ab"}, {oa, ob}, exp);
    check_eq({tag, "_dec"}, dec(oa, ob), {a, b});
  endtask

  initial begin
    logic [31:0] l [0:3];
    logic [31:0] ka, kb;
    int ki, kj, lat;

    s_tab[0] = 32'hB7E15163;
    for (int i = 1; i < T; i++) s_tab[i] = s_tab[i-1] + 32'h9E3779B9;
    for (int i = 0; i < 4; i++) l[i] = '0;
    ka = '0; kb = '0; ki = 0; kj = 0;
    for (int k = 0; k < 3 * T; k++) begin
      s_tab[ki] = rotl(s_tab[ki] + ka + kb, 3);
      ka = s_tab[ki];
      l[kj] = rotl(l[kj] + ka + kb, int'(5'(ka + kb)));
      kb = l[kj];
      ki = (ki + 1) % T;
      kj = (kj + 1) % 4;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_a", 64'(oa), 64'h0);
    check_eq("rst_b", 64'(ob), 64'h0);
    check_eq("rst_done", 64'(odone), 64'h0);
    check_eq("rst_addr1", 64'(addr1), 64'h0);
    check_eq("rst_addr2", 64'(addr2), 64'h1);
    rst = 1'b0;

    // All-zero plaintext against the published RC5-32/12 vector
    ia = '0; ib = '0;
    trace_en = 1'b1;
    istart = 1'b1;
    wait_done(lat);
    trace_en = 1'b0;
    check_eq("zero_lat", 64'(lat), 64'(LAT));
    check_eq("zero_a", 64'(oa), 64'hEEDBA521);
    check_eq("zero_b", 64'(ob), 64'h6D8F4B15);
    check_eq("trace_len", 64'(trace_q.size()), 64'(R + 1));
    for (int k = 0; k < trace_q.size() && k <= R; k++) check_eq($sformatf("trace_%0d", k), 64'(trace_q[k]), 64'(2 * k));

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("hold_done", 64'(odone), 64'h1);
    check_eq("hold_ab", {oa, ob}, 64'hEEDBA521_6D8F4B15);

    // Reset pulse during HOLD with iStart still high
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("hrst_done", 64'(odone), 64'h0);
    check_eq("hrst_ab", {oa, ob}, 64'h0);
    rst = 1'b0;
    wait_done(lat);
    check_eq("hrst_lat", 64'(lat), 64'(LAT));
    check_eq("hrst_res", {oa, ob}, 64'hEEDBA521_6D8F4B15);

    run_vec("vec2", 32'h12345678, 32'h9ABCDEF0);
    run_vec("rot0", 32'hA5A5A5A5, 32'hABCDEF00);
    run_vec("rot31", 32'hFFFFFFFF, 32'h1234561F);

    // Abort mid-round, then restart from scratch
    go_idle();
    ia = '0; ib = '0;
    istart = 1'b1;
    for (int e = 1; e < 50; e++) begin
      @(posedge clk);
      @(negedge clk);
    end
    istart = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_ab", {oa, ob}, 64'h0);
    check_eq("abort_done", 64'(odone), 64'h0);
    check_eq("abort_addr", {addr1, addr2}, {TL'(0), TL'(1)});
    istart = 1'b1;
    wait_done(lat);
    check_eq("abort_lat", 64'(lat), 64'(LAT));
    check_eq("abort_res", {oa, ob}, 64'hEEDBA521_6D8F4B15);

    check_eq("addr_legal", 64'(addr_bad), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/encipher.md
ENCIPHER -- requirements
Module: encipher

Interface
REQ-001 W, 32, word width in bits; power of two (16, 32, 64).
REQ-002 R, 12, number of RC5 rounds, at least 1.
REQ-003 Derived: T = 2*(R+1) subkeys; T_LENGTH = clog2(T) address bits; ROT_VALUE = clog2(W) rotate-amount bits.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 iStart  in  1  level enable; high runs and holds the encryption, low aborts it and returns the block to reset state.
REQ-007 iA, iB  in  W each  plaintext words A and B; sampled once, in INIT.
REQ-008 oS_address1, oS_address2  out  T_LENGTH each  registered subkey-table read addresses; always even and even+1.
REQ-009 iS_sub_i1, iS_sub_i2  in  W each  subkey words S[oS_address1] and S[oS_address2] from the external table.
REQ-010 oA_cipher, oB_cipher  out  W each  registered working/ciphertext words.
REQ-011 oDone  out  1  registered; high once the ciphertext is final; stays high while iStart is high.

Function
REQ-012 Computes RC5 encryption: A=A+S[0], B=B+S[1]; for i=1..R: A=((A^B)<<<B)+S[2i], B=((B^A)<<<A)+S[2i+1]; all additions modulo 2^W.
REQ-013 Rotation is left, by the low ROT_VALUE bits of the other word, through one instance of the team's barrel rotator with direction fixed to left.
REQ-014 Round counter is clog2(R+1) bits wide, starts at 1, and counts up to R.
REQ-015 States: IDLE, INIT, WAIT_ADDR, READ_DATA, ADD_S01, CHANGE_ADDR, XOR_A, ROT_A, ADD_A, XOR_B, ROT_B, ADD_B, HOLD.
REQ-016 IDLE->INIT when iStart is high; INIT loads A=iA and B=iB, then goes to WAIT_ADDR.
REQ-017 The subkey table has synchronous read: the address is held stable through WAIT_ADDR and READ_DATA, and iS_sub_i1/2 are used only in the following add state.
REQ-018 First pass WAIT_ADDR->READ_DATA->ADD_S01; ADD_S01 adds S[0] and S[1], then goes to CHANGE_ADDR.
REQ-019 CHANGE_ADDR loads addresses 2*count and 2*count+1, then goes to WAIT_ADDR->READ_DATA->XOR_A->ROT_A->ADD_A->XOR_B->ROT_B->ADD_B.
REQ-020 In ADD_B: if count==R, set oDone and go to HOLD; otherwise increment count and go to CHANGE_ADDR.
REQ-021 HOLD keeps all outputs unchanged until iStart falls.
REQ-022 Latency, counting the IDLE->INIT edge as edge 1: oDone rises on edge 5+9R; for R=12 that is edge 113.
REQ-023 Address arithmetic is performed at T_LENGTH width and never exceeds T-1.
REQ-024 rst or low iStart at any state, including mid-round, takes effect on the next edge; iStart re-asserted afterwards starts a fresh encryption from IDLE.
REQ-025 Unused or illegal state encodings go to IDLE.

Reset
REQ-026 On a clock edge with rst high or iStart low: state=IDLE, oS_address1=0, oS_address2=1, oA_cipher=0, oB_cipher=0, count=1, rotator operand and amount registers=0, oDone=0.
REQ-027 rst has priority over every other condition.

Configuration
REQ-028 Macro ENCIPHER_MERGE_XOR_EN.
REQ-029 When defined: XOR_A/ROT_A and XOR_B/ROT_B are merged into single states, with the rotator fed combinationally from A^B and B^A; this gives 7 cycles per round and oDone on edge 5+7R (89 for R=12).
REQ-030 When undefined: the separate states of REQ-019 are used and the latency of REQ-022 applies; ciphertext is identical in both builds.

Verification
REQ-031 W=32, R=12, S from the RC5 key schedule of the all-zero 16-byte key, iA=0, iB=0 -> oA_cipher=32'hEEDBA521 and oB_cipher=32'h6D8F4B15, with oDone on edge 113 (89 with ENCIPHER_MERGE_XOR_EN).
REQ-032 Same table, iA=32'h12345678, iB=32'h9ABCDEF0 -> outputs match the software RC5-32/12 model, and decrypting them through the team's RC5 decryption block returns the plaintext.
REQ-033 Address trace -> (0,1), then (2,3), (4,5), up to (24,25); each pair is held for at least 2 cycles before use, and no address is ever 26 or above.
REQ-034 iStart dropped at edge 50 -> on the next edge all outputs are at reset values; iStart re-raised gives the same ciphertext as REQ-031 with full latency.
REQ-035 rst pulsed for 1 cycle while in HOLD -> oDone=0 and outputs=0 on the next edge; a new run follows if iStart is still high.
REQ-036 Inputs with the low 5 bits of B = 0 and = 31 (rotate-amount extremes) -> results match the software model.
